// File: rtl/saida_serial_pkg.sv
// saida_serial_pkg -- shared types, constants and helpers for the serial
// output stage (saida_serial_fd and its transmitter tx_serial_7o1).
//
// Configuration macro: SAIDA_SERIAL_PARITY_EN
//   defined   : frame = start, d0..d6, odd parity, stop (10 bits)
//   undefined : frame = start, d0..d6, stop (9 bits)
package saida_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TX   = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SEL_D2   = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_D0   = 2'b10;
    localparam logic [1:0] SEL_HASH = 2'b11;

    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_A    = 7'h41;
    localparam logic [6:0] ASCII_HASH = 7'h23;

    // Index of the stop bit, i.e. the last bit of a frame (start is bit 0).
`ifdef SAIDA_SERIAL_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd9;
`else
    localparam logic [3:0] LAST_BIT = 4'd8;
`endif

    // Hex digit to 7-bit ASCII: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [6:0] nibble_to_ascii(input logic [3:0] nib);
        logic [6:0] code;
        if (nib < 4'd10) begin
            code = ASCII_ZERO + {3'b000, nib};
        end else begin
            code = ASCII_A + {3'b000, nib} - 7'd10;
        end
        return code;
    endfunction

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [6:0] data);
        return ~(^data);
    endfunction

    // Bits that follow the start bit, LSB first. Without parity the extra
    // top bit is a spare stop level that is never shifted out.
    function automatic logic [8:0] frame_tail(input logic [6:0] data);
`ifdef SAIDA_SERIAL_PARITY_EN
        return {1'b1, odd_parity(data), data};
`else
        return {1'b1, 1'b1, data};
`endif
    endfunction

endpackage

// File: rtl/tx_serial_7o1.sv
// tx_serial_7o1 -- generic 7-bit asynchronous serial transmitter.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   partida      in   start request, sampled while idle (level)
//   dado[6:0]    in   character to send, latched when the frame starts
//   saida_serial out  registered TX line, idle high
//   pronto       out  one-cycle pulse after the stop bit
//
// Parameter BAUD_DIV: clock cycles per serial bit (>= 1).
// Parity bit present only when SAIDA_SERIAL_PARITY_EN is defined.
module tx_serial_7o1
    import saida_serial_pkg::*;
#(
    parameter int BAUD_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dado,
    output logic       saida_serial,
    output logic       pronto
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(32'd0);

    state_t        state_r;
    logic [8:0]    shift_r;
    logic [3:0]    bit_cnt_r;
    logic [CW-1:0] baud_cnt_r;
    logic          saida_r;
    logic          pronto_r;

    // Frame sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            shift_r    <= 9'd0;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= BAUD_ZERO;
            saida_r    <= 1'b1;
            pronto_r   <= 1'b0;
        end else begin
            case (state_r)
                // DONE also samples partida so that a held request restarts
                // right after the single DONE (idle-high) cycle.
                IDLE, DONE: begin
                    pronto_r   <= 1'b0;
                    bit_cnt_r  <= 4'd0;
                    baud_cnt_r <= BAUD_ZERO;
                    if (partida) begin
                        shift_r <= frame_tail(dado);
                        saida_r <= 1'b0;
                        state_r <= TX;
                    end else begin
                        saida_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                // bit_cnt_r is the index of the bit currently on the line.
                TX: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= 4'd0;
                            saida_r   <= 1'b1;
                            pronto_r  <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            saida_r   <= shift_r[0];
                            shift_r   <= {1'b1, shift_r[8:1]};
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    shift_r    <= 9'd0;
                    bit_cnt_r  <= 4'd0;
                    baud_cnt_r <= BAUD_ZERO;
                    saida_r    <= 1'b1;
                    pronto_r   <= 1'b0;
                end
            endcase
        end
    end

    assign saida_serial = saida_r;
    assign pronto       = pronto_r;

endmodule

// File: rtl/saida_serial_fd.sv
// saida_serial_fd -- serial output stage datapath.
// Picks one of three packed hex digits (or '#'), converts it to ASCII and
// hands it to the UART transmitter.
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   proximo           in   send request (level, sampled while idle)
//   selecao_mux[1:0]  in   00 dados[11:8], 01 dados[7:4], 10 dados[3:0], 11 '#'
//   dados[11:0]       in   three packed 4-bit digits, most significant first
//   saida_serial      out  UART TX line, idle high
//   serial_pronto     out  one-cycle pulse when a frame completes
//
// Parameter BAUD_DIV: clock cycles per serial bit (>= 1).
// Configuration macro SAIDA_SERIAL_PARITY_EN adds the odd parity bit.
module saida_serial_fd
    import saida_serial_pkg::*;
#(
    parameter int BAUD_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proximo,
    input  logic [1:0]  selecao_mux,
    input  logic [11:0] dados,
    output logic        saida_serial,
    output logic        serial_pronto
);

    logic [6:0] ascii_s;

    // Character select and hex-to-ASCII conversion; the transmitter latches
    // the result, so later input changes do not affect a frame in flight.
    always_comb begin
        ascii_s = ASCII_HASH;
        case (selecao_mux)
            SEL_D2:   ascii_s = nibble_to_ascii(dados[11:8]);
            SEL_D1:   ascii_s = nibble_to_ascii(dados[7:4]);
            SEL_D0:   ascii_s = nibble_to_ascii(dados[3:0]);
            SEL_HASH: ascii_s = ASCII_HASH;
            default:  ascii_s = ASCII_HASH;
        endcase
    end

    tx_serial_7o1 #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clock        (clock),
        .reset        (reset),
        .partida      (proximo),
        .dado         (ascii_s),
        .saida_serial (saida_serial),
        .pronto       (serial_pronto)
    );

endmodule

// File: tb/tb_saida_serial_fd.sv
// tb_saida_serial_fd -- self-checking bench for saida_serial_fd.
// Two instances share clock and reset: one with BAUD_DIV=1, one with
// BAUD_DIV=4. A waveform model per instance predicts line and pronto for
// every cycle; directed tests add hand-computed literal expectations.
module tb_saida_serial_fd;

`ifdef SAIDA_SERIAL_PARITY_EN
    localparam int FB = 10;
    localparam logic [15:0] EXP_PR_VEC = 16'h0400;
    localparam logic [15:0] EXP_HASH   = 16'hFE46;
    localparam logic [15:0] EXP_LAT4   = 16'd41;
`else
    localparam int FB = 9;
    localparam logic [15:0] EXP_PR_VEC = 16'h0200;
    localparam logic [15:0] EXP_HASH   = 16'hFF46;
    localparam logic [15:0] EXP_LAT4   = 16'd37;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prox1 = 1'b0, prox4 = 1'b0;
    logic [1:0]  sel1 = 2'b00, sel4 = 2'b00;
    logic [11:0] dat1 = 12'h000, dat4 = 12'h000;
    logic        line1, pr1, line4, pr4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    saida_serial_fd #(.BAUD_DIV(1)) dut1 (
        .clock(clk), .reset(rst_n), .proximo(prox1), .selecao_mux(sel1),
        .dados(dat1), .saida_serial(line1), .serial_pronto(pr1));

    saida_serial_fd #(.BAUD_DIV(4)) dut4 (
        .clock(clk), .reset(rst_n), .proximo(prox4), .selecao_mux(sel4),
        .dados(dat4), .saida_serial(line4), .serial_pronto(pr4));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits from the character rules, index 0 = start bit.
    function automatic logic [9:0] model_frame(input logic [1:0] s, input logic [11:0] d);
        int n;
        int code;
        logic [6:0] c;
        case (s)
            2'd0:    n = int'(d[11:8]);
            2'd1:    n = int'(d[7:4]);
            2'd2:    n = int'(d[3:0]);
            default: n = -1;
        endcase
        if (n < 0)       code = 35;
        else if (n < 10) code = 48 + n;
        else             code = 65 + n - 10;
        c = code[6:0];
`ifdef SAIDA_SERIAL_PARITY_EN
        return {1'b1, ($countones(c) % 2 == 0), c, 1'b0};
`else
        return {1'b1, 1'b1, c, 1'b0};
`endif
    endfunction

    // Model state: queued {line, pronto} values for the cycles ahead.
    logic [1:0] q1[$];
    logic [1:0] q4[$];
    logic [1:0] cur1 = 2'b10;
    logic [1:0] cur4 = 2'b10;

    always @(posedge clk or negedge rst_n) begin
        logic [9:0] f;
        if (!rst_n) begin
            q1.delete();
            cur1 = 2'b10;
        end else begin
            if (q1.size() == 0 && prox1) begin
                f = model_frame(sel1, dat1);
                for (int i = 0; i < FB; i++) q1.push_back({f[i], 1'b0});
                q1.push_back(2'b11);
            end
            if (q1.size() > 0) cur1 = q1.pop_front();
            else               cur1 = 2'b10;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        logic [9:0] f;
        if (!rst_n) begin
            q4.delete();
            cur4 = 2'b10;
        end else begin
            if (q4.size() == 0 && prox4) begin
                f = model_frame(sel4, dat4);
                for (int i = 0; i < FB; i++)
                    for (int j = 0; j < 4; j++) q4.push_back({f[i], 1'b0});
                q4.push_back(2'b11);
            end
            if (q4.size() > 0) cur4 = q4.pop_front();
            else               cur4 = 2'b10;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("line1", {15'd0, line1}, {15'd0, cur1[1]});
            check("pronto1", {15'd0, pr1}, {15'd0, cur1[0]});
            check("line4", {15'd0, line4}, {15'd0, cur4[1]});
            check("pronto4", {15'd0, pr4}, {15'd0, cur4[0]});
        end
    end

    // One request on dut1, then 16 cycles of line/pronto captured, bit n =
    // n-th cycle after the latching edge.
    task automatic pulse_capture(input logic [1:0] s, input logic [11:0] d, input bit perturb,
                                 output logic [15:0] ln, output logic [15:0] pr);
        @(negedge clk);
        sel1 = s; dat1 = d; prox1 = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            prox1 = 1'b0;
            if (perturb && n == 3) begin
                dat1 = 12'hFFF;
                sel1 = 2'b00;
            end
            ln[n] = line1;
            pr[n] = pr1;
        end
    endtask

    initial begin
        logic [15:0] ln, pr;
        int cnt;
        int lat;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_line1", {15'd0, line1}, 16'd1);
        check("rst_pronto1", {15'd0, pr1}, 16'd0);
        check("rst_line4", {15'd0, line4}, 16'd1);
        check("rst_pronto4", {15'd0, pr4}, 16'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // '5' from dados[11:8]
        pulse_capture(2'b00, 12'h5A3, 1'b0, ln, pr);
        check("five_line", ln, 16'hFF6A);
        check("five_pronto", pr, EXP_PR_VEC);

        // 'A' from dados[7:4]
        pulse_capture(2'b01, 12'hAAA, 1'b0, ln, pr);
        check("a_line", ln, 16'hFF82);

        // '9' from dados[3:0]
        pulse_capture(2'b10, 12'h009, 1'b0, ln, pr);
        check("nine_line", ln, 16'hFF72);

        // '#' with inputs changed mid-frame
        pulse_capture(2'b11, 12'h123, 1'b1, ln, pr);
        check("hash_line", ln, EXP_HASH);
        check("hash_pronto", pr, EXP_PR_VEC);

        // Request re-asserted mid-frame is ignored
        @(negedge clk);
        sel1 = 2'b01; dat1 = 12'hAAA; prox1 = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            prox1 = (n == 4 || n == 5);
            cnt += int'(pr1);
        end
        check("midframe_pronto_count", 16'(cnt), 16'd1);

        // Request held high: back-to-back frames, one idle cycle between
        @(negedge clk);
        sel1 = 2'b10; dat1 = 12'h009; prox1 = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int n = 0; n < 3 * (FB + 1); n++) begin
            @(negedge clk);
            if (n == 3 * FB + 2) prox1 = 1'b0;
            if (n == FB)     check("b2b_gap_high", {15'd0, line1}, 16'd1);
            if (n == FB + 1) check("b2b_next_start", {15'd0, line1}, 16'd0);
            cnt += int'(pr1);
        end
        check("b2b_pronto_count", 16'(cnt), 16'd3);
        repeat (4) @(negedge clk);

        // BAUD_DIV=4 latency
        @(negedge clk);
        sel4 = 2'b00; dat4 = 12'h5A3; prox4 = 1'b1;
        @(posedge clk);
        lat = 0; found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            prox4 = 1'b0;
            if (pr4) begin
                found = 1'b1;
                lat = n + 1;
            end
        end
        if (!found) check("lat4_timeout", 16'd0, 16'd1);
        else        check("lat4", 16'(lat), EXP_LAT4);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-frame
        @(negedge clk);
        sel1 = 2'b11; prox1 = 1'b1;
        sel4 = 2'b11; prox4 = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            prox1 = 1'b0;
            prox4 = 1'b0;
        end
        check("pre_reset_line1", {15'd0, line1}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_line1", {15'd0, line1}, 16'd1);
        check("async_rst_pronto1", {15'd0, pr1}, 16'd0);
        check("async_rst_line4", {15'd0, line4}, 16'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("post_rst_idle", {14'd0, line1, line4}, 16'd3);
            check("post_rst_no_pronto", {14'd0, pr1, pr4}, 16'd0);
        end

        // One more BAUD_DIV=4 frame after reset
        @(negedge clk);
        sel4 = 2'b10; dat4 = 12'h00E; prox4 = 1'b1;
        @(negedge clk);
        prox4 = 1'b0;
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
